ff_bank: RTL and testbench
==========================

Name: ff_bank

Overview:
- Parametrised multi-channel successor to the two-input single-bit flip-flop.
- WIDTH independent channels. Each channel has two control inputs (in1, in2) and runtime-selectable semantics: set-dominant SR, reset-dominant SR, JK, or D-with-enable.
- Optional input synchroniser stages, global clock enable, and per-channel change-detect pulses.
- Used as the general state-bit primitive for control/status flags in the design.

Parameters:
- WIDTH, 4: number of channels (1..32).
- SYNC_STAGES, 0: flip-flop stages on in1/in2 before the state logic (0..3; 0 = direct).
- RESET_VAL, {WIDTH{1'b0}}: value loaded into out on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global clock enable for state update.
- mode  input  2  channel semantics, shared by all channels: 0 = SR set-dominant, 1 = SR reset-dominant, 2 = JK, 3 = D/enable.
- in1  input  WIDTH  per-channel set / J / D.
- in2  input  WIDTH  per-channel reset / K / load-enable.
- out  output  WIDTH  registered channel state.
- out_chg  output  WIDTH  one-cycle pulse: channel out changed at the last edge.
- any_chg  output  1  OR of out_chg (registered alongside out_chg, same cycle).

Behaviour:
- Reset:
  - rst high immediately forces out = RESET_VAL, out_chg = 0, any_chg = 0, and all sync stages = 0, independent of clk.
  - Release is synchronous to the next rising edge; the first update happens at the first edge with rst low.
- Synchroniser:
  - in1 and in2 each pass through SYNC_STAGES flops.
  - The state logic sees s1/s2. With SYNC_STAGES = 0, s1 = in1 and s2 = in2 combinationally.
- Latency: an input stable before edge k affects out at edge k + SYNC_STAGES.
- mode and en are not synchronised. They are sampled at the same edge that updates out.
- Next-state per channel i when en = 1 (q = out[i], a = s1[i], b = s2[i]):
  - mode 0: a=1 → 1; else b=1 → 0; else hold. a=b=1 → 1.
  - mode 1: b=1 → 0; else a=1 → 1; else hold. a=b=1 → 0.
  - mode 2: 00 hold, 10 → 1, 01 → 0, 11 → ~q (toggle every enabled edge while held).
  - mode 3: b=1 → q = a; b=0 → hold.
- When en = 0:
  - out holds and out_chg = 0, whatever the inputs and mode.
  - Sync stages keep shifting regardless of en.
- out_chg[i] is registered: set at the edge where out[i] takes a new value, and high for exactly the cycle in which the new value is visible. It is 0 otherwise.
- A continuous toggle (mode 2, a=b=1) gives out_chg = 1 every enabled cycle.
- A mode change mid-stream takes effect at the next edge with no glitch cycle. State is preserved across a mode change.
- Reset asserted mid-operation: pulses in flight in the sync stages are discarded, and state returns to RESET_VAL.
- Channels are fully independent. No cross-channel priority.

Test Plan:
- WIDTH=4, SYNC=0, mode 0. Release reset at 50 ns; 1-cycle pulse in1=4'b0001, then 1-cycle pulse in2=4'b0001 → out = 0001 one edge after in1, back to 0000 one edge after in2; out_chg[0] pulses twice; any_chg matches.
- mode 0 vs mode 1 with in1=in2=4'b1010 held 2 cycles from out=0000 → mode 0: out = 1010, out_chg pulse once; mode 1: out stays 0000, out_chg = 0.
- mode 2, in1=in2=4'b0110 held 3 edges from 0000 → out: 0110, 0000, 0110; out_chg = 0110 on each of the 3 cycles.
- mode 3, in1=4'b1111, in2=4'b0011 → out = 0011; then en=0 with in2=1111 → out holds 0011, out_chg = 0.
- SYNC_STAGES=2, RESET_VAL=4'b1000, mode 0. After reset, out = 1000. in1[1] pulse at edge k → out[1] rises at edge k+2; rst asserted 1 ns after the pulse is captured in the first stage → out = 1000 immediately, and no later set occurs.

Source files
------------

// File: rtl/ff_bank.sv
// rtl/ff_bank.sv - multi-channel configurable state-bit flip-flop bank
//
// WIDTH independent channels, each a set-dominant SR, reset-dominant SR,
// JK or D-with-enable flop depending on the shared mode input.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   en       global enable for the state update
//   mode     0 SR set-dom, 1 SR reset-dom, 2 JK, 3 D/enable
//   in1      per-channel set / J / D
//   in2      per-channel reset / K / load-enable
//   out      registered channel state
//   out_chg  one-cycle pulse per channel when out changed at the last edge
//   any_chg  OR of out_chg, registered together with it
module ff_bank #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_chg,
  output logic             any_chg
);

  localparam logic [1:0] MODE_SR_SET = 2'd0;
  localparam logic [1:0] MODE_SR_RST = 2'd1;
  localparam logic [1:0] MODE_JK     = 2'd2;
  localparam logic [1:0] MODE_D      = 2'd3;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] nxt;

  // Input synchroniser chains; they shift every edge, independent of en.
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s1 = in1;
      assign s2 = in2;
    end else begin : g_sync
      logic [WIDTH-1:0] st1 [SYNC_STAGES];
      logic [WIDTH-1:0] st2 [SYNC_STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            st1[i] <= '0;
            st2[i] <= '0;
          end
        end else begin
          st1[0] <= in1;
          st2[0] <= in2;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            st1[i] <= st1[i-1];
            st2[i] <= st2[i-1];
          end
        end
      end

      assign s1 = st1[SYNC_STAGES-1];
      assign s2 = st2[SYNC_STAGES-1];
    end
  endgenerate

  // Bitwise next-state equations; every channel evaluates independently.
  always_comb begin
    nxt = out;
    if (en) begin
      case (mode)
        MODE_SR_SET: nxt = s1 | (out & ~s2);
        MODE_SR_RST: nxt = ~s2 & (s1 | out);
        MODE_JK:     nxt = (s1 & ~out) | (~s2 & out);
        MODE_D:      nxt = (s2 & s1) | (~s2 & out);
        default:     nxt = out;
      endcase
    end
  end

  // Change flags are computed from the pending update so they line up
  // with the cycle in which the new value is visible on out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= RESET_VAL;
      out_chg <= '0;
      any_chg <= 1'b0;
    end else begin
      out     <= nxt;
      out_chg <= nxt ^ out;
      any_chg <= |(nxt ^ out);
    end
  end

endmodule

// File: tb/tb_ff_bank.sv
// tb/tb_ff_bank.sv - self-checking bench for ff_bank (direct and 2-stage synchronised)
module tb_ff_bank;

  logic       clk = 1'b0;
  logic       rst0, rst2;
  logic       en;
  logic [1:0] mode;
  logic [3:0] in1, in2;
  logic [3:0] out0, chg0, out2, chg2;
  logic       any0, any2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(4), .SYNC_STAGES(0), .RESET_VAL(4'b0000)) u_direct (
    .clk(clk), .rst(rst0), .en(en), .mode(mode), .in1(in1), .in2(in2),
    .out(out0), .out_chg(chg0), .any_chg(any0)
  );

  ff_bank #(.WIDTH(4), .SYNC_STAGES(2), .RESET_VAL(4'b1000)) u_sync (
    .clk(clk), .rst(rst2), .en(en), .mode(mode), .in1(in1), .in2(in2),
    .out(out2), .out_chg(chg2), .any_chg(any2)
  );

  // Reference model state
  bit [3:0] m0_q, m0_chg, m2_q, m2_chg;
  bit [7:0] m2_hist[$];

  typedef struct {
    bit       en;
    bit [1:0] mode;
    bit [3:0] in1;
    bit [3:0] in2;
    bit [3:0] q;
    bit [3:0] chg;
    bit       any;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic bit next_bit(bit [1:0] md, bit q, bit a, bit b);
    case (md)
      2'd0: begin
        if (a) return 1'b1;
        else if (b) return 1'b0;
        else return q;
      end
      2'd1: begin
        if (b) return 1'b0;
        else if (a) return 1'b1;
        else return q;
      end
      2'd2: begin
        if (a && b) return !q;
        else if (a) return 1'b1;
        else if (b) return 1'b0;
        else return q;
      end
      default: return b ? a : q;
    endcase
  endfunction

  function automatic bit [3:0] next_vec(bit [1:0] md, bit [3:0] q, bit [3:0] a, bit [3:0] b);
    bit [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = next_bit(md, q[i], a[i], b[i]);
    return r;
  endfunction

  task automatic model_reset0();
    m0_q   = 4'b0000;
    m0_chg = 4'b0000;
  endtask

  task automatic model_reset2();
    m2_q   = 4'b1000;
    m2_chg = 4'b0000;
    m2_hist.delete();
    m2_hist.push_back(8'h00);
    m2_hist.push_back(8'h00);
  endtask

  task automatic model_step();
    bit [3:0] n;
    bit [7:0] e;
    if (rst0) model_reset0();
    else begin
      n      = en ? next_vec(mode, m0_q, in1, in2) : m0_q;
      m0_chg = n ^ m0_q;
      m0_q   = n;
    end
    if (rst2) model_reset2();
    else begin
      e = m2_hist.pop_front();
      m2_hist.push_back({in1, in2});
      n      = en ? next_vec(mode, m2_q, e[7:4], e[3:0]) : m2_q;
      m2_chg = n ^ m2_q;
      m2_q   = n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst2 = 1'b1;
    en = 1'b1; mode = 2'd0; in1 = 4'b0000; in2 = 4'b0000;
    model_reset0();
    model_reset2();

    //            en mode   in1      in2      q        chg      any
    tbl[0]  = '{1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1};
    tbl[1]  = '{1'b1, 2'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    tbl[2]  = '{1'b1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 1'b1};
    tbl[4]  = '{1'b1, 2'd0, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 4'b0000, 4'b1111, 4'b0000, 4'b1010, 1'b1};
    tbl[6]  = '{1'b1, 2'd1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 1'b1};
    tbl[9]  = '{1'b1, 2'd2, 4'b0110, 4'b0110, 4'b0000, 4'b0110, 1'b1};
    tbl[10] = '{1'b1, 2'd2, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 1'b1};
    tbl[11] = '{1'b1, 2'd0, 4'b0000, 4'b1111, 4'b0000, 4'b0110, 1'b1};
    tbl[12] = '{1'b1, 2'd3, 4'b1111, 4'b0011, 4'b0011, 4'b0011, 1'b1};
    tbl[13] = '{1'b0, 2'd3, 4'b1111, 4'b1111, 4'b0011, 4'b0000, 1'b0};
    tbl[14] = '{1'b1, 2'd3, 4'b0000, 4'b1111, 4'b0000, 4'b0011, 1'b1};
    tbl[15] = '{1'b0, 2'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    // Reset state while rst is still high
    #40;
    check("rst_out0", out0, 4'b0000);
    check("rst_chg0", chg0, 4'b0000);
    check("rst_any0", {3'b000, any0}, 4'b0000);
    check("rst_out2", out2, 4'b1000);
    check("rst_chg2", chg2, 4'b0000);
    #10;
    rst0 = 1'b0; rst2 = 1'b0;

    // Directed vectors on the unsynchronised bank
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; in1 = tbl[i].in1; in2 = tbl[i].in2;
      tick();
      check($sformatf("vec%0d_out", i), out0, tbl[i].q);
      check($sformatf("vec%0d_chg", i), chg0, tbl[i].chg);
      check($sformatf("vec%0d_any", i), {3'b000, any0}, {3'b000, tbl[i].any});
    end

    // Asynchronous reset of the direct bank from a non-reset state
    en = 1'b1; mode = 2'd0; in1 = 4'b0101; in2 = 4'b0000;
    tick();
    check("pre_arst_out0", out0, 4'b0101);
    rst0 = 1'b1;
    model_reset0();
    #1;
    check("arst_out0", out0, 4'b0000);
    check("arst_chg0", chg0, 4'b0000);
    rst0 = 1'b0;

    // Two-stage synchroniser latency
    en = 1'b1; mode = 2'd0; in1 = 4'b0000; in2 = 4'b0000;
    rst2 = 1'b1;
    model_reset2();
    #1;
    check("sync_rst_out", out2, 4'b1000);
    rst2 = 1'b0;
    in1 = 4'b0010;
    tick();
    check("sync_lat_k", out2, 4'b1000);
    in1 = 4'b0000;
    tick();
    check("sync_lat_k1", out2, 4'b1000);
    tick();
    check("sync_lat_k2_out", out2, 4'b1010);
    check("sync_lat_k2_chg", chg2, 4'b0010);
    check("sync_lat_k2_any", {3'b000, any2}, 4'b0001);

    // Reset while a pulse sits in the first stage discards it
    in1 = 4'b0100;
    tick();
    in1 = 4'b0000;
    rst2 = 1'b1;
    model_reset2();
    #1;
    check("sync_arst_out", out2, 4'b1000);
    check("sync_arst_chg", chg2, 4'b0000);
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sync_flush%0d_out", i), out2, 4'b1000);
      check($sformatf("sync_flush%0d_chg", i), chg2, 4'b0000);
    end

    // Randomised run of both banks against the model
    rst0 = 1'b1; rst2 = 1'b1;
    model_reset0();
    model_reset2();
    tick();
    rst0 = 1'b0; rst2 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      in1  = 4'($urandom);
      in2  = 4'($urandom);
      tick();
      check("rnd_out0", out0, m0_q);
      check("rnd_chg0", chg0, m0_chg);
      check("rnd_any0", {3'b000, any0}, {3'b000, |m0_chg});
      check("rnd_out2", out2, m2_q);
      check("rnd_chg2", chg2, m2_chg);
      check("rnd_any2", {3'b000, any2}, {3'b000, |m2_chg});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
